// File: rtl/spi_counter_slave_rx_if.sv
// SPI pin bundle between the counter master and the remote-board slave receiver.
interface spi_counter_slave_rx_if;
  logic sclk;
  logic mosi;
  logic ss;
  logic miso;

  modport master (output sclk, output mosi, output ss, input miso);
  modport slave  (input sclk, input mosi, input ss, output miso);
endinterface

// File: rtl/spi_counter_slave_rx.sv
// SPI mode-0 slave: rebuilds the 14-bit counter from a 2-byte frame, reads back the last
// accepted value on miso, and flags malformed frames. sclk is oversampled on clk.
module spi_counter_slave_rx #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          PAD_CHECK   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  spi_counter_slave_rx_if.slave spi,
  output logic [13:0]           o_counter,
  output logic                  o_valid,
  output logic                  o_frame_err,
  output logic [7:0]            o_rx_byte,
  output logic                  o_byte_valid,
  output logic [7:0]            o_good_cnt
);
  localparam int unsigned BOOT_W = 3;
  localparam logic [BOOT_W-1:0] BOOT_MAX = BOOT_W'(SYNC_STAGES + 2);

  typedef enum logic [2:0] {IDLE, RX_HI, RX_LO, WAIT_END, ERR} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] ss_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_d;
  logic                   ss_d;
  logic [BOOT_W-1:0]      boot_cnt;
  logic [3:0]             bit_cnt;
  logic [7:0]             shift_reg;
  logic [7:0]             hi_reg;
  logic [7:0]             lo_reg;
  logic [15:0]            tx_reg;
  logic                   miso_q;

  logic       sclk_s, ss_s, mosi_s;
  logic       sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic       booted;
  logic [7:0] byte_next;
  logic [15:0] readback;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign ss_rise   = ss_s & ~ss_d;
  assign ss_fall   = ~ss_s & ss_d;
  assign booted    = (boot_cnt == BOOT_MAX);
  assign byte_next = {shift_reg[6:0], mosi_s};
  assign readback  = {2'b00, o_counter};
  assign spi.miso  = miso_q;

  // Pin synchronisers, edge-detect copies and a short post-reset window used to spot ss held low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_sync <= '0;
      ss_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      ss_d      <= 1'b1;
      boot_cnt  <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.sclk};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi.ss};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.mosi};
      sclk_d    <= sclk_s;
      ss_d      <= ss_s;
      if (!booted) boot_cnt <= boot_cnt + BOOT_W'(1);
    end
  end

  // Frame FSM with registered outputs; ss edges take priority over sclk edges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      tx_reg       <= '0;
      miso_q       <= 1'b0;
      o_counter    <= '0;
      o_valid      <= 1'b0;
      o_frame_err  <= 1'b0;
      o_rx_byte    <= '0;
      o_byte_valid <= 1'b0;
      o_good_cnt   <= '0;
    end else begin
      o_valid      <= 1'b0;
      o_frame_err  <= 1'b0;
      o_byte_valid <= 1'b0;

      // Readback shifter: preload on a fresh frame, advance on sclk falling edges.
      if (ss_s) begin
        miso_q <= 1'b0;
      end else if (ss_fall) begin
        if (state == IDLE && booted) begin
          miso_q <= readback[15];
          tx_reg <= {readback[14:0], 1'b0};
        end
      end else if (sclk_fall) begin
        miso_q <= tx_reg[15];
        tx_reg <= {tx_reg[14:0], 1'b0};
      end

      unique case (state)
        IDLE: begin
          if (ss_fall) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
            state     <= booted ? RX_HI : ERR;
          end
        end
        RX_HI, RX_LO: begin
          if (ss_rise) begin
            o_frame_err <= 1'b1;
            shift_reg   <= '0;
            state       <= IDLE;
          end else if (!ss_fall && sclk_rise) begin
            bit_cnt   <= bit_cnt + 4'd1;
            shift_reg <= byte_next;
            if (bit_cnt[2:0] == 3'd7) begin
              o_rx_byte    <= byte_next;
              o_byte_valid <= 1'b1;
              if (state == RX_HI) begin
                hi_reg <= byte_next;
                state  <= RX_LO;
              end else begin
                lo_reg <= byte_next;
                state  <= WAIT_END;
              end
            end
          end
        end
        WAIT_END: begin
          if (ss_rise) begin
            if (PAD_CHECK && (hi_reg[7:6] != 2'b00)) begin
              o_frame_err <= 1'b1;
            end else begin
              o_counter  <= {hi_reg[5:0], lo_reg};
              o_valid    <= 1'b1;
              o_good_cnt <= o_good_cnt + 8'd1;
            end
            state <= IDLE;
          end else if (!ss_fall && sclk_rise) begin
            bit_cnt <= bit_cnt + 4'd1;
            state   <= ERR;
          end
        end
        ERR: begin
          if (ss_rise) begin
            o_frame_err <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_counter_slave_rx.sv
// Scoreboard bench for spi_counter_slave_rx: two instances (SYNC 2/PAD on, SYNC 3/PAD off)
// share one SPI stimulus; frame outcomes, bytes and miso readback are compared against a model.
module tb_spi_counter_slave_rx;
  typedef struct {
    bit         is_err;
    logic [13:0] cnt;
    logic [7:0]  good;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic sclk, mosi, ss;

  logic [13:0] a_counter, b_counter;
  logic        a_valid, b_valid, a_err, b_err, a_bv, b_bv;
  logic [7:0]  a_rx, b_rx, a_good, b_good;
  logic        a_valid_prev, b_valid_prev, a_err_prev, b_err_prev;

  exp_t        q_a[$];
  exp_t        q_b[$];
  logic [7:0]  q_byte[$];
  exp_t        ea, eb;
  logic [7:0]  eb_byte;

  logic [13:0] cnt_a, cnt_b;
  logic [7:0]  good_a, good_b;
  int          n_checks = 0;
  int          n_errors = 0;

  spi_counter_slave_rx_if spi_a ();
  spi_counter_slave_rx_if spi_b ();
  assign spi_a.sclk = sclk;
  assign spi_a.mosi = mosi;
  assign spi_a.ss   = ss;
  assign spi_b.sclk = sclk;
  assign spi_b.mosi = mosi;
  assign spi_b.ss   = ss;

  spi_counter_slave_rx #(.SYNC_STAGES(2), .PAD_CHECK(1'b1)) dut_a (
    .clk(clk), .reset(reset), .spi(spi_a),
    .o_counter(a_counter), .o_valid(a_valid), .o_frame_err(a_err),
    .o_rx_byte(a_rx), .o_byte_valid(a_bv), .o_good_cnt(a_good));

  spi_counter_slave_rx #(.SYNC_STAGES(3), .PAD_CHECK(1'b0)) dut_b (
    .clk(clk), .reset(reset), .spi(spi_b),
    .o_counter(b_counter), .o_valid(b_valid), .o_frame_err(b_err),
    .o_rx_byte(b_rx), .o_byte_valid(b_bv), .o_good_cnt(b_good));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Frame-result monitors, sampled on the falling clk edge.
  always @(negedge clk) begin
    a_valid_prev <= a_valid;
    a_err_prev   <= a_err;
    if (reset && (a_valid || a_err)) begin
      check("a_excl", 32'(a_valid & a_err), 32'(0));
      check("a_pulse_len", 32'((a_valid & a_valid_prev) | (a_err & a_err_prev)), 32'(0));
      check("a_evt_expected", 32'(q_a.size() != 0), 32'(1));
      if (q_a.size() != 0) begin
        ea = q_a.pop_front();
        check("a_kind_err", 32'(a_err), 32'(ea.is_err));
        if (!ea.is_err) begin
          check("a_counter", 32'(a_counter), 32'(ea.cnt));
          check("a_good_cnt", 32'(a_good), 32'(ea.good));
        end
      end
    end
  end

  always @(negedge clk) begin
    b_valid_prev <= b_valid;
    b_err_prev   <= b_err;
    if (reset && (b_valid || b_err)) begin
      check("b_excl", 32'(b_valid & b_err), 32'(0));
      check("b_pulse_len", 32'((b_valid & b_valid_prev) | (b_err & b_err_prev)), 32'(0));
      check("b_evt_expected", 32'(q_b.size() != 0), 32'(1));
      if (q_b.size() != 0) begin
        eb = q_b.pop_front();
        check("b_kind_err", 32'(b_err), 32'(eb.is_err));
        if (!eb.is_err) begin
          check("b_counter", 32'(b_counter), 32'(eb.cnt));
          check("b_good_cnt", 32'(b_good), 32'(eb.good));
        end
      end
    end
  end

  // Byte monitor on the SYNC_STAGES=2 instance.
  always @(negedge clk) begin
    if (reset && a_bv) begin
      check("a_byte_expected", 32'(q_byte.size() != 0), 32'(1));
      if (q_byte.size() != 0) begin
        eb_byte = q_byte.pop_front();
        check("a_rx_byte", 32'(a_rx), 32'(eb_byte));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Clocks nbits mode-0 bits (4 clk low, 4 clk high) and records miso just before each rise.
  task automatic shift_bits(input logic [15:0] word, input int nbits,
                            output logic [15:0] got_a, output logic [15:0] got_b);
    got_a = '0;
    got_b = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = (i < 16) ? word[4'(15 - i)] : 1'b0;
      tick(4);
      if (i < 16) begin
        got_a[4'(15 - i)] = spi_a.miso;
        got_b[4'(15 - i)] = spi_b.miso;
      end
      sclk = 1'b1;
      tick(4);
      sclk = 1'b0;
    end
  endtask

  task automatic push_err();
    q_a.push_back('{is_err: 1'b1, cnt: '0, good: '0});
    q_b.push_back('{is_err: 1'b1, cnt: '0, good: '0});
  endtask

  task automatic frame(input logic [15:0] word, input int nbits);
    logic [15:0] rb_a, rb_b, got_a, got_b;
    rb_a = {2'b00, cnt_a};
    rb_b = {2'b00, cnt_b};
    if (nbits >= 8)  q_byte.push_back(word[15:8]);
    if (nbits >= 16) q_byte.push_back(word[7:0]);
    ss = 1'b0;
    tick(6);
    shift_bits(word, nbits, got_a, got_b);
    tick(6);
    if (nbits == 16) begin
      if (word[15:14] == 2'b00) begin
        cnt_a  = word[13:0];
        good_a = good_a + 8'd1;
        q_a.push_back('{is_err: 1'b0, cnt: cnt_a, good: good_a});
      end else begin
        q_a.push_back('{is_err: 1'b1, cnt: '0, good: '0});
      end
      cnt_b  = word[13:0];
      good_b = good_b + 8'd1;
      q_b.push_back('{is_err: 1'b0, cnt: cnt_b, good: good_b});
    end else begin
      push_err();
    end
    ss = 1'b1;
    if (nbits >= 16) begin
      check("a_miso_word", 32'(got_a), 32'(rb_a));
      check("b_miso_word", 32'(got_b), 32'(rb_b));
    end
    tick(10);
  endtask

  task automatic check_outs(input string tag);
    check({tag, "_a_counter"}, 32'(a_counter), 32'(cnt_a));
    check({tag, "_b_counter"}, 32'(b_counter), 32'(cnt_b));
    check({tag, "_a_good"}, 32'(a_good), 32'(good_a));
    check({tag, "_b_good"}, 32'(b_good), 32'(good_b));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_a_counter"}, 32'(a_counter), 32'(0));
    check({tag, "_b_counter"}, 32'(b_counter), 32'(0));
    check({tag, "_a_good"}, 32'(a_good), 32'(0));
    check({tag, "_b_good"}, 32'(b_good), 32'(0));
    check({tag, "_a_rx"}, 32'(a_rx), 32'(0));
    check({tag, "_b_rx"}, 32'(b_rx), 32'(0));
    check({tag, "_pulses"}, 32'({a_valid, a_err, a_bv, b_valid, b_err, b_bv}), 32'(0));
    check({tag, "_miso"}, 32'({spi_a.miso, spi_b.miso}), 32'(0));
  endtask

  task automatic model_reset();
    cnt_a  = '0;
    cnt_b  = '0;
    good_a = '0;
    good_b = '0;
  endtask

  initial begin
    logic [15:0] ga, gb;
    reset = 1'b0;
    sclk  = 1'b0;
    mosi  = 1'b0;
    ss    = 1'b1;
    model_reset();
    tick(3);
    check_reset_vals("rst");
    reset = 1'b1;
    tick(8);

    frame(16'h1234, 16);
    check_outs("t1");
    check("t1_good_one", 32'(a_good), 32'(1));

    frame(16'h3FFF, 16);
    check_outs("t2a");
    frame(16'h0000, 16);
    check_outs("t2b");

    frame(16'hABCD, 11);
    check_outs("t3_short");
    frame(16'h05A0, 16);
    check_outs("t3_good");
    frame(16'h0000, 0);
    check_outs("empty");

    frame(16'h1357, 17);
    check_outs("t4_long");
    frame(16'hC15A, 16);
    check_outs("t4_pad");

    // Reset mid-frame, released with ss still low.
    q_byte.push_back(8'hA5);
    ss = 1'b0;
    tick(6);
    shift_bits(16'hA5C3, 9, ga, gb);
    tick(4);
    reset = 1'b0;
    tick(3);
    model_reset();
    reset = 1'b1;
    tick(6);
    shift_bits(16'h1234, 7, ga, gb);
    tick(6);
    check_reset_vals("t5_held");
    push_err();
    ss = 1'b1;
    tick(10);
    frame(16'h002A, 16);
    check_outs("t5_next");

    // 256 accepted frames from reset wrap the good-frame counter.
    reset = 1'b0;
    tick(2);
    model_reset();
    reset = 1'b1;
    tick(8);
    for (int k = 0; k < 256; k++) frame({2'b00, 14'($urandom)}, 16);
    check_outs("t6");
    check("t6_a_wrap", 32'(a_good), 32'(0));
    check("t6_b_wrap", 32'(b_good), 32'(0));

    tick(10);
    check("a_evt_left", 32'(q_a.size()), 32'(0));
    check("b_evt_left", 32'(q_b.size()), 32'(0));
    check("byte_left", 32'(q_byte.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
